waterfall_reader: RTL and testbench
===================================

WATERFALL_READER -- requirements
Module: waterfall_reader

Interface
REQ-001 SHALL have parameter X0, default 64: left pixel column of the 512x256 waterfall window.
REQ-002 SHALL have parameter Y0, default 112: top pixel row of the waterfall window.
REQ-003 SHALL have parameter RAM_LAT, default 2: read latency of the waterfall frame memory, in cycles.
REQ-004 rd_clk  in  1  pixel clock; the only clock in the block.
REQ-005 rd_rst  in  1  synchronous, active-high reset.
REQ-006 h_count  in  10  current pixel column, 0..639 when active.
REQ-007 v_count  in  10  current pixel row, 0..479 when active.
REQ-008 active_draw  in  1  pixel is inside the visible area.
REQ-009 h_sync_in, v_sync_in  in  1 each  timing syncs.
REQ-010 new_frame  in  1  one-cycle pulse at the start of each frame.
REQ-011 gain  in  2  magnitude left-shift amount, 0..3.
REQ-012 cmap_sel  in  1  0 = grayscale, 1 = heat map.
REQ-013 rd_bin  out  9  frequency-bin read address to the waterfall buffer.
REQ-014 rd_row  out  8  history-row read address (0 = newest) to the waterfall buffer.
REQ-015 rd_data  in  8  log-magnitude returned by the buffer RAM_LAT cycles after the address.
REQ-016 red, green, blue  out  8 each  pixel colour.
REQ-017 h_sync_out, v_sync_out, active_draw_out  out  1 each  syncs aligned to the colour outputs.

Function
REQ-018 SHALL treat in_win as true when active_draw=1, X0<=h_count<=X0+511 and Y0<=v_count<=Y0+255.
REQ-019 Stage 0: rd_bin SHALL be registered as h_count-X0 (low 9 bits) and rd_row as v_count-Y0 (low 8 bits) when in_win=1, else 0.
REQ-020 SHALL delay in_win, active_draw, h_sync_in and v_sync_in through a shift pipeline of depth 1+RAM_LAT, so they align with rd_data.
REQ-021 Gain stage: m = rd_data << gain, saturated to 255; for example rd_data=0x50 with gain=2 gives 0xFF, and rd_data=0x20 with gain=2 gives 0x80.
REQ-022 Grayscale (cmap_sel=0): red=green=blue=m.
REQ-023 Heat map (cmap_sel=1):
- m<85: R=3m, G=0, B=0.
- 85<=m<170: R=255, G=3(m-85), B=0.
- m>=170: R=255, G=255, B=3(m-170).
- All products SHALL be computed at least 10 bits wide before truncation to 8 bits.
REQ-024 The colour stage SHALL be registered; total latency from h_count/v_count to red/green/blue and the *_out syncs SHALL be 2+RAM_LAT cycles (4 at the default).
REQ-025 Delayed in_win=0 SHALL force RGB to 0x000000; the delayed syncs and active_draw SHALL still pass through unchanged.
REQ-026 gain and cmap_sel SHALL be latched into shadow registers only on a new_frame pulse; mid-frame changes SHALL take effect at the next frame.
REQ-027 State machine, states WAIT_FRAME and RUN:
- Reset SHALL enter WAIT_FRAME.
- WAIT_FRAME->RUN on the first new_frame.
- RUN has no exit other than rd_rst.
REQ-028 In WAIT_FRAME the block SHALL force RGB to 0, while syncs still propagate through the pipeline.
REQ-029 The first RUN pixel coloured SHALL be the pixel whose address was issued in the new_frame cycle or later; pixels already in the pipeline SHALL stay black.
REQ-030 new_frame arriving in the same cycle as rd_rst SHALL be ignored.
REQ-031 new_frame while in RUN SHALL only re-latch the shadow registers.

Reset
REQ-032 On rd_rst=1 the block SHALL clear all outputs and all pipeline stages to 0, clear shadow gain and cmap_sel to 0, and enter WAIT_FRAME.
REQ-033 A reset asserted mid-frame SHALL blank the display until the next new_frame after reset deasserts.

Verification
REQ-034 Reset, then new_frame, then h=64, v=112 with rd_data=0x40 and cmap 0, gain 0 -> rd_bin=0, rd_row=0 one cycle later; RGB=0x404040 four cycles after the address.
REQ-035 Pixel at h=575, v=367 -> rd_bin=511, rd_row=255; pixels at h=576 or h=63 -> RGB=0 and rd_bin=0.
REQ-036 Heat map, gain 0, rd_data values 0x00, 0x54, 0x55, 0xAA, 0xFF -> RGB 000000, FC0000, FF0000, FFFF00, FFFFFF.
REQ-037 gain=3 with rd_data=0x30 -> m=0xFF (saturated); gain changed mid-frame -> output unchanged until the next new_frame.
REQ-038 No new_frame after reset, in-window pixels with rd_data=0xFF -> RGB stays 0 while h_sync_out/v_sync_out track the inputs delayed by 4 cycles.
REQ-039 rd_rst asserted mid-frame -> all outputs 0 the next cycle; black until a new_frame after reset is released.

Source files
------------

// File: rtl/waterfall_reader.sv
// Waterfall display reader: maps the raster position onto a 512x256 history
// window, issues bin/row reads to the waterfall frame memory, and turns the
// returned log-magnitude into a grayscale or heat-map pixel. Syncs are
// delayed to line up with the colour outputs.
module waterfall_reader #(
  parameter int X0      = 64,
  parameter int Y0      = 112,
  parameter int RAM_LAT = 2
) (
  input  logic       rd_clk,
  input  logic       rd_rst,
  input  logic [9:0] h_count,
  input  logic [9:0] v_count,
  input  logic       active_draw,
  input  logic       h_sync_in,
  input  logic       v_sync_in,
  input  logic       new_frame,
  input  logic [1:0] gain,
  input  logic       cmap_sel,
  output logic [8:0] rd_bin,
  output logic [7:0] rd_row,
  input  logic [7:0] rd_data,
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] blue,
  output logic       h_sync_out,
  output logic       v_sync_out,
  output logic       active_draw_out
);

  // Stage 0 plus RAM_LAT memory cycles; the last stage lines up with rd_data.
  localparam int DEPTH = 1 + RAM_LAT;

  typedef enum logic [0:0] {
    WAIT_FRAME = 1'b0,
    RUN        = 1'b1
  } state_t;

  state_t state_q;
  state_t state_d;

  logic in_win;
  logic live;

  logic [1:0] gain_q;
  logic       cmap_q;

  // Delay lines. win_p carries "in window and allowed to be coloured".
  logic [DEPTH-1:0] win_p;
  logic [DEPTH-1:0] act_p;
  logic [DEPTH-1:0] hs_p;
  logic [DEPTH-1:0] vs_p;

  logic [10:0] m_wide;
  logic [7:0]  m;
  logic [7:0]  red_d;
  logic [7:0]  green_d;
  logic [7:0]  blue_d;

  // Window decode on the raw raster position.
  always_comb begin
    in_win = active_draw
          && (int'(h_count) >= X0) && (int'(h_count) <= X0 + 511)
          && (int'(v_count) >= Y0) && (int'(v_count) <= Y0 + 255);
  end

  // A pixel may be coloured if its address is issued while running or in
  // the very cycle new_frame starts the run.
  always_comb begin
    live = (state_q == RUN) || new_frame;
  end

  // Next-state logic: leave WAIT_FRAME on the first new_frame, RUN is sticky.
  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_FRAME: if (new_frame) state_d = RUN;
      RUN:        state_d = RUN;
      default:    state_d = WAIT_FRAME;
    endcase
  end

  // State register; reset wins over a coincident new_frame.
  always_ff @(posedge rd_clk) begin
    if (rd_rst) state_q <= WAIT_FRAME;
    else        state_q <= state_d;
  end

  // Shadow copies of gain/colour map so changes only land on frame boundaries.
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      gain_q <= 2'd0;
      cmap_q <= 1'b0;
    end else if (new_frame) begin
      gain_q <= gain;
      cmap_q <= cmap_sel;
    end
  end

  // Stage 0 address registers and the alignment delay lines.
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      rd_bin <= 9'd0;
      rd_row <= 8'd0;
      win_p  <= '0;
      act_p  <= '0;
      hs_p   <= '0;
      vs_p   <= '0;
    end else begin
      rd_bin   <= in_win ? 9'(h_count - 10'(X0)) : 9'd0;
      rd_row   <= in_win ? 8'(v_count - 10'(Y0)) : 8'd0;
      win_p[0] <= in_win && live;
      act_p[0] <= active_draw;
      hs_p[0]  <= h_sync_in;
      vs_p[0]  <= v_sync_in;
      for (int i = 1; i < DEPTH; i++) begin
        win_p[i] <= win_p[i-1];
        act_p[i] <= act_p[i-1];
        hs_p[i]  <= hs_p[i-1];
        vs_p[i]  <= vs_p[i-1];
      end
    end
  end

  // Gain with saturation, then grayscale or three-segment heat map.
  always_comb begin
    m_wide  = 11'(rd_data) << gain_q;
    m       = (|m_wide[10:8]) ? 8'hFF : m_wide[7:0];
    red_d   = 8'd0;
    green_d = 8'd0;
    blue_d  = 8'd0;
    if (!cmap_q) begin
      red_d   = m;
      green_d = m;
      blue_d  = m;
    end else if (m < 8'd85) begin
      red_d   = 8'(10'(m) * 10'd3);
    end else if (m < 8'd170) begin
      red_d   = 8'hFF;
      green_d = 8'((10'(m) - 10'd85) * 10'd3);
    end else begin
      red_d   = 8'hFF;
      green_d = 8'hFF;
      blue_d  = 8'((10'(m) - 10'd170) * 10'd3);
    end
  end

  // Registered colour stage; pixels outside the live window are black.
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      red             <= 8'd0;
      green           <= 8'd0;
      blue            <= 8'd0;
      h_sync_out      <= 1'b0;
      v_sync_out      <= 1'b0;
      active_draw_out <= 1'b0;
    end else begin
      red             <= win_p[DEPTH-1] ? red_d   : 8'd0;
      green           <= win_p[DEPTH-1] ? green_d : 8'd0;
      blue            <= win_p[DEPTH-1] ? blue_d  : 8'd0;
      h_sync_out      <= hs_p[DEPTH-1];
      v_sync_out      <= vs_p[DEPTH-1];
      active_draw_out <= act_p[DEPTH-1];
    end
  end

endmodule

// File: tb/tb_waterfall_reader.sv
// Directed bench for waterfall_reader with a two-cycle-latency memory model.
module tb_waterfall_reader;

  logic       rd_clk = 1'b0;
  logic       rd_rst = 1'b0;
  logic [9:0] h_count = '0;
  logic [9:0] v_count = '0;
  logic       active_draw = 1'b0;
  logic       h_sync_in = 1'b0;
  logic       v_sync_in = 1'b0;
  logic       new_frame = 1'b0;
  logic [1:0] gain = '0;
  logic       cmap_sel = 1'b0;
  logic [8:0] rd_bin;
  logic [7:0] rd_row;
  logic [7:0] rd_data;
  logic [7:0] red, green, blue;
  logic       h_sync_out, v_sync_out, active_draw_out;

  int checks = 0;
  int failures = 0;

  logic [7:0]  mem [512];
  logic [7:0]  d1 = '0;
  logic [7:0]  d2 = '0;
  logic [7:0]  heat_in  [7];
  logic [23:0] heat_exp [7];

  waterfall_reader dut (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .h_count(h_count), .v_count(v_count),
    .active_draw(active_draw), .h_sync_in(h_sync_in), .v_sync_in(v_sync_in),
    .new_frame(new_frame), .gain(gain), .cmap_sel(cmap_sel),
    .rd_bin(rd_bin), .rd_row(rd_row), .rd_data(rd_data),
    .red(red), .green(green), .blue(blue),
    .h_sync_out(h_sync_out), .v_sync_out(v_sync_out),
    .active_draw_out(active_draw_out)
  );

  // Clock.
  always #5 rd_clk = ~rd_clk;

  // Frame memory model: data appears two cycles after the registered address.
  always @(posedge rd_clk) begin
    d1 <= mem[rd_bin];
    d2 <= d1;
  end
  assign rd_data = d2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge rd_clk);
    #1;
  endtask

  task automatic set_px(input int h, input int v, input logic ad);
    h_count = 10'(h);
    v_count = 10'(v);
    active_draw = ad;
  endtask

  task automatic idle();
    set_px(0, 0, 1'b0);
    h_sync_in = 1'b0;
    v_sync_in = 1'b0;
    new_frame = 1'b0;
  endtask

  task automatic frame(input logic [1:0] g, input logic c);
    gain = g;
    cmap_sel = c;
    new_frame = 1'b1;
    tick();
    new_frame = 1'b0;
  endtask

  // One isolated pixel: address checked after 1 cycle, colour after 4.
  task automatic pixel(input string tag, input int h, input int v, input logic ad,
                       input logic [8:0] eb, input logic [7:0] er, input logic [23:0] ergb);
    set_px(h, v, ad);
    tick();
    check({tag, "_bin"}, 32'(rd_bin), 32'(eb));
    check({tag, "_row"}, 32'(rd_row), 32'(er));
    idle();
    tick(); tick(); tick();
    check({tag, "_rgb"}, 32'({red, green, blue}), 32'(ergb));
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 8'h00;
    mem[0] = 8'h40; mem[1] = 8'h11; mem[2] = 8'hFF; mem[6] = 8'h40;
    mem[511] = 8'h80;
    mem[20] = 8'h30; mem[21] = 8'h20; mem[22] = 8'h50;
    heat_in[0] = 8'h00; heat_exp[0] = 24'h000000;
    heat_in[1] = 8'h54; heat_exp[1] = 24'hFC0000;
    heat_in[2] = 8'h55; heat_exp[2] = 24'hFF0000;
    heat_in[3] = 8'hAA; heat_exp[3] = 24'hFFFF00;
    heat_in[4] = 8'hFF; heat_exp[4] = 24'hFFFFFF;
    heat_in[5] = 8'h80; heat_exp[5] = 24'hFF8100;
    heat_in[6] = 8'hC8; heat_exp[6] = 24'hFFFF5A;
    for (int k = 0; k < 7; k++) mem[10 + k] = heat_in[k];

    // Reset state.
    rd_rst = 1'b1;
    idle();
    tick(); tick();
    check("rst_rgb", 32'({red, green, blue}), 32'h0);
    check("rst_bin", 32'(rd_bin), 32'h0);
    check("rst_hs", 32'(h_sync_out), 32'h0);

    // new_frame coincident with reset is ignored.
    new_frame = 1'b1;
    gain = 2'd3;
    cmap_sel = 1'b1;
    tick();
    rd_rst = 1'b0;
    new_frame = 1'b0;
    gain = 2'd0;
    cmap_sel = 1'b0;

    // Waiting for a frame: black output, syncs delayed by four cycles.
    set_px(66, 112, 1'b1);
    h_sync_in = 1'b1;
    v_sync_in = 1'b1;
    tick();
    check("wait_bin", 32'(rd_bin), 32'd2);
    idle();
    tick(); tick();
    check("wait_hs_early", 32'(h_sync_out), 32'h0);
    tick();
    check("wait_hs", 32'(h_sync_out), 32'h1);
    check("wait_vs", 32'(v_sync_out), 32'h1);
    check("wait_ad", 32'(active_draw_out), 32'h1);
    check("wait_rgb", 32'({red, green, blue}), 32'h0);
    tick();
    check("wait_hs_drop", 32'(h_sync_out), 32'h0);

    // Pixel before new_frame stays black; pixel in the new_frame cycle is coloured.
    set_px(65, 112, 1'b1);
    tick();
    set_px(64, 112, 1'b1);
    new_frame = 1'b1;
    tick();
    check("nf_bin", 32'(rd_bin), 32'h0);
    check("nf_row", 32'(rd_row), 32'h0);
    idle();
    tick(); tick();
    check("pre_nf_rgb", 32'({red, green, blue}), 32'h0);
    tick();
    check("nf_rgb", 32'({red, green, blue}), 32'h404040);

    // Window corners and outside pixels.
    pixel("corner", 575, 367, 1'b1, 9'd511, 8'd255, 24'h808080);
    pixel("h576", 576, 200, 1'b1, 9'd0, 8'd0, 24'h0);
    pixel("h63", 63, 200, 1'b1, 9'd0, 8'd0, 24'h0);
    pixel("v368", 100, 368, 1'b1, 9'd0, 8'd0, 24'h0);
    pixel("v111", 100, 111, 1'b1, 9'd0, 8'd0, 24'h0);
    pixel("noact", 64, 112, 1'b0, 9'd0, 8'd0, 24'h0);

    // Heat map segments and boundaries.
    frame(2'd0, 1'b1);
    for (int k = 0; k < 7; k++)
      pixel($sformatf("heat%0d", k), 74 + k, 112, 1'b1, 9'(10 + k), 8'd0, heat_exp[k]);

    // Gain and saturation; mid-frame change waits for the next frame.
    frame(2'd3, 1'b0);
    pixel("g3_sat", 84, 113, 1'b1, 9'd20, 8'd1, 24'hFFFFFF);
    frame(2'd2, 1'b0);
    pixel("g2_20", 85, 113, 1'b1, 9'd21, 8'd1, 24'h808080);
    pixel("g2_50", 86, 113, 1'b1, 9'd22, 8'd1, 24'hFFFFFF);
    gain = 2'd0;
    pixel("g_hold", 85, 113, 1'b1, 9'd21, 8'd1, 24'h808080);
    frame(2'd0, 1'b0);
    pixel("g0_20", 85, 113, 1'b1, 9'd21, 8'd1, 24'h202020);

    // Mid-frame reset blanks until a fresh new_frame.
    set_px(70, 120, 1'b1);
    h_sync_in = 1'b1;
    v_sync_in = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("run_rgb", 32'({red, green, blue}), 32'h404040);
    check("run_bin", 32'(rd_bin), 32'd6);
    rd_rst = 1'b1;
    tick();
    check("mrst_rgb", 32'({red, green, blue}), 32'h0);
    check("mrst_hs", 32'(h_sync_out), 32'h0);
    check("mrst_vs", 32'(v_sync_out), 32'h0);
    check("mrst_ad", 32'(active_draw_out), 32'h0);
    check("mrst_bin", 32'(rd_bin), 32'h0);
    check("mrst_row", 32'(rd_row), 32'h0);
    rd_rst = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("post_rst_rgb", 32'({red, green, blue}), 32'h0);
    check("post_rst_hs", 32'(h_sync_out), 32'h1);
    new_frame = 1'b1;
    tick();
    new_frame = 1'b0;
    tick(); tick();
    check("post_nf_black", 32'({red, green, blue}), 32'h0);
    tick();
    check("post_nf_rgb", 32'({red, green, blue}), 32'h404040);
    idle();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
